weight_bias_loader: RTL and testbench

WEIGHT_BIAS_LOADER -- requirements
Module: weight_bias_loader

---
 rtl/weight_bias_loader.sv | 155 +++++++++++++++
 tb/tb_weight_bias_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_bias_loader.sv
// Configuration-stream loader: parses a header word, then forwards weight or
// bias payload words to the neuron array as registered one-cycle strobes.
module weight_bias_loader #(
    parameter int INPUTS_NUM = 784,
    parameter int DATA_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_cfg_data,
    input  logic        i_cfg_valid,
    output logic        o_cfg_ready,
    input  logic        i_abort,
    output logic [31:0] o_weight_value,
    output logic        o_weight_valid,
    output logic [31:0] o_bias_value,
    output logic        o_bias_valid,
    output logic [31:0] o_layer_id,
    output logic [31:0] o_neuron_id,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error
);

    if (DATA_WIDTH < 1 || DATA_WIDTH > 32 || INPUTS_NUM < 1 || INPUTS_NUM > 65535) begin : g_bad_params
        $error("weight_bias_loader: DATA_WIDTH must be 1..32 and INPUTS_NUM 1..65535");
    end

    localparam logic [15:0] MAX_COUNT = 16'(INPUTS_NUM);

    // Handshake: a word moves when i_cfg_valid and o_cfg_ready are high in the
    // same cycle; the producer holds data stable while valid is high and not taken.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WEIGHT = 2'd1,
        BIAS   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_count;
    logic        r_cfg_ready;
    logic [31:0] r_weight_value;
    logic        r_weight_valid;
    logic [31:0] r_bias_value;
    logic        r_bias_valid;
    logic [5:0]  r_layer_id;
    logic [7:0]  r_neuron_id;
    logic        r_done;
    logic        r_error;

    logic        w_xfer;
    logic [1:0]  w_hdr_type;
    logic [15:0] w_hdr_count;
    logic        w_weight_hdr_ok;
    logic        w_bias_hdr;
    logic        w_hdr_accept;
    logic        w_hdr_error;
    logic        w_abort_hit;
    logic        w_weight_take;
    logic        w_bias_take;

    assign w_xfer          = i_cfg_valid && r_cfg_ready;
    assign w_hdr_type      = i_cfg_data[31:30];
    assign w_hdr_count     = i_cfg_data[15:0];
    assign w_weight_hdr_ok = (w_hdr_type == 2'b01) && (w_hdr_count != 16'd0)
                             && (w_hdr_count <= MAX_COUNT);
    assign w_bias_hdr      = (w_hdr_type == 2'b10);
    assign w_hdr_accept    = (r_state == IDLE) && w_xfer && (w_weight_hdr_ok || w_bias_hdr);
    assign w_hdr_error     = (r_state == IDLE) && w_xfer && !(w_weight_hdr_ok || w_bias_hdr);
    assign w_abort_hit     = i_abort && ((r_state == WEIGHT) || (r_state == BIAS));
    // A word offered in the abort cycle is swallowed without a strobe.
    assign w_weight_take   = (r_state == WEIGHT) && w_xfer && !i_abort;
    assign w_bias_take     = (r_state == BIAS) && w_xfer && !i_abort;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_xfer && w_weight_hdr_ok)
                    w_next_state = WEIGHT;
                else if (w_xfer && w_bias_hdr)
                    w_next_state = BIAS;
            end
            WEIGHT: begin
                if (i_abort)
                    w_next_state = IDLE;
                else if (w_xfer && (r_count == 16'd1))
                    w_next_state = DONE;
            end
            BIAS: begin
                if (i_abort)
                    w_next_state = IDLE;
                else if (w_xfer)
                    w_next_state = DONE;
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_count        <= 16'd0;
            r_cfg_ready    <= 1'b0;
            r_weight_value <= 32'd0;
            r_weight_valid <= 1'b0;
            r_bias_value   <= 32'd0;
            r_bias_valid   <= 1'b0;
            r_layer_id     <= 6'd0;
            r_neuron_id    <= 8'd0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            // Ready is registered from the next state so it drops exactly in DONE.
            r_cfg_ready    <= (w_next_state != DONE);
            r_weight_valid <= w_weight_take;
            r_bias_valid   <= w_bias_take;
            r_done         <= (r_state == DONE);
            r_error        <= w_hdr_error || w_abort_hit;

            if (w_hdr_accept) begin
                r_layer_id  <= i_cfg_data[29:24];
                r_neuron_id <= i_cfg_data[23:16];
                if (w_weight_hdr_ok)
                    r_count <= w_hdr_count;
            end

            if (w_weight_take) begin
                r_weight_value <= i_cfg_data;
                r_count        <= r_count - 16'd1;
            end

            if (w_bias_take)
                r_bias_value <= i_cfg_data;

            if (w_abort_hit)
                r_count <= 16'd0;
        end
    end

    assign o_cfg_ready    = r_cfg_ready;
    assign o_weight_value = r_weight_value;
    assign o_weight_valid = r_weight_valid;
    assign o_bias_value   = r_bias_value;
    assign o_bias_valid   = r_bias_valid;
    assign o_layer_id     = {26'd0, r_layer_id};
    assign o_neuron_id    = {24'd0, r_neuron_id};
    assign o_busy         = (r_state != IDLE);
    assign o_done         = r_done;
    assign o_error        = r_error;

endmodule

// File: tb/tb_weight_bias_loader.sv
// Directed bench for weight_bias_loader: stimulus pushes expected output events
// into a queue, a negedge monitor pops and compares every strobe/done/error.
module tb_weight_bias_loader;

    logic        clk;
    logic        reset;
    logic [31:0] i_cfg_data;
    logic        i_cfg_valid;
    logic        o_cfg_ready;
    logic        i_abort;
    logic [31:0] o_weight_value;
    logic        o_weight_valid;
    logic [31:0] o_bias_value;
    logic        o_bias_valid;
    logic [31:0] o_layer_id;
    logic [31:0] o_neuron_id;
    logic        o_busy;
    logic        o_done;
    logic        o_error;

    weight_bias_loader #(.INPUTS_NUM(784), .DATA_WIDTH(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_cfg_data     (i_cfg_data),
        .i_cfg_valid    (i_cfg_valid),
        .o_cfg_ready    (o_cfg_ready),
        .i_abort        (i_abort),
        .o_weight_value (o_weight_value),
        .o_weight_valid (o_weight_valid),
        .o_bias_value   (o_bias_value),
        .o_bias_valid   (o_bias_valid),
        .o_layer_id     (o_layer_id),
        .o_neuron_id    (o_neuron_id),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_error        (o_error)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    localparam logic [1:0] K_W = 2'd0;
    localparam logic [1:0] K_B = 2'd1;
    localparam logic [1:0] K_D = 2'd2;
    localparam logic [1:0] K_E = 2'd3;

    logic [47:0] exp_q[$];
    logic [5:0]  exp_layer;
    logic [7:0]  exp_neuron;
    int          n_checks;
    int          n_pass;
    int          cyc;
    int          last_strobe_cyc;
    int          n_ready_low;
    int          n_wstrobe;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    endtask

    task automatic push_ev(input logic [1:0] kind, input logic [31:0] val);
        exp_q.push_back({kind, val, exp_layer, exp_neuron});
    endtask

    task automatic pop_cmp(input logic [1:0] kind, input logic [31:0] val);
        logic [47:0] act_ev;
        logic [47:0] exp_ev;
        act_ev = {kind, val, o_layer_id[5:0], o_neuron_id[7:0]};
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_event: got 0x%0h expected none at %0t", act_ev, $time);
        end else begin
            exp_ev = exp_q.pop_front();
            chk("event", {16'd0, act_ev}, {16'd0, exp_ev});
            chk("id_zero_ext", {30'd0, o_layer_id[31:6], o_neuron_id[31:8]}, 64'd0);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!reset) begin
            cyc++;
            if (!o_cfg_ready)
                n_ready_low++;
            if (o_weight_valid || o_bias_valid)
                chk("strobe_exclusive", {63'd0, o_weight_valid & o_bias_valid}, 64'd0);
            if (o_weight_valid) begin
                n_wstrobe++;
                last_strobe_cyc = cyc;
                pop_cmp(K_W, o_weight_value);
            end
            if (o_bias_valid) begin
                last_strobe_cyc = cyc;
                pop_cmp(K_B, o_bias_value);
            end
            if (o_done) begin
                chk("done_timing", 64'(cyc), 64'(last_strobe_cyc + 1));
                pop_cmp(K_D, 32'd0);
            end
            if (o_error)
                pop_cmp(K_E, 32'd0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        i_cfg_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offers one word and returns #1 after the edge that transferred it.
    task automatic send(input logic [31:0] w);
        int t;
        i_cfg_data  = w;
        i_cfg_valid = 1'b1;
        t = 0;
        while (!o_cfg_ready && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 100)
            chk("ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        i_cfg_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ready_low0;
        int wstrobe0;
        n_checks = 0; n_pass = 0; cyc = 0; last_strobe_cyc = -10;
        n_ready_low = 0; n_wstrobe = 0;
        exp_layer = 6'd0; exp_neuron = 8'd0;
        reset = 1'b1; i_cfg_data = 32'd0; i_cfg_valid = 1'b0; i_abort = 1'b0;

        // Reset state
        #8;
        chk("reset_ready", {63'd0, o_cfg_ready}, 64'd0);
        chk("reset_outs", {o_weight_value, o_bias_value},       64'd0);
        chk("reset_ids",  {o_layer_id, o_neuron_id},            64'd0);
        chk("reset_flags", {59'd0, o_weight_valid, o_bias_valid, o_busy, o_done, o_error}, 64'd0);
        #4 reset = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_release", {63'd0, o_cfg_ready}, 64'd1);
        chk("idle_not_busy", {63'd0, o_busy}, 64'd0);

        // Three-weight packet, back-to-back payload
        ready_low0 = n_ready_low;
        exp_layer = 6'd1; exp_neuron = 8'd3;
        push_ev(K_W, 32'h11); push_ev(K_W, 32'h22); push_ev(K_W, 32'h33); push_ev(K_D, 32'd0);
        send(32'h4103_0003);
        chk("busy_in_weight", {63'd0, o_busy}, 64'd1);
        send(32'h11); send(32'h22); send(32'h33);
        idle(4);
        chk("weight3_ready_low_cycles", 64'(n_ready_low - ready_low0), 64'd1);

        // Single bias packet
        exp_layer = 6'd2; exp_neuron = 8'd0;
        push_ev(K_B, 32'h0000_0100); push_ev(K_D, 32'd0);
        send(32'h8200_0005);
        send(32'h0000_0100);
        idle(4);

        // Rejected headers: count 0, count 785, type 11
        ready_low0 = n_ready_low;
        push_ev(K_E, 32'd0); push_ev(K_E, 32'd0); push_ev(K_E, 32'd0);
        send(32'h4100_0000);
        send(32'h4100_0311);
        send(32'hC000_0001);
        idle(3);
        chk("err_ids_layer", o_layer_id, 64'd2);
        chk("err_ids_neuron", o_neuron_id, 64'd0);
        chk("err_not_busy", {63'd0, o_busy}, 64'd0);
        chk("err_ready_low_cycles", 64'(n_ready_low - ready_low0), 64'd0);

        // Full 784-weight packet with random valid gaps
        ready_low0 = n_ready_low;
        wstrobe0 = n_wstrobe;
        exp_layer = 6'd1; exp_neuron = 8'd5;
        for (int i = 0; i < 784; i++)
            push_ev(K_W, 32'hA500_0000 | 32'(i));
        push_ev(K_D, 32'd0);
        send(32'h4105_0310);
        for (int i = 0; i < 784; i++) begin
            idle($urandom_range(0, 2));
            send(32'hA500_0000 | 32'(i));
        end
        idle(4);
        chk("w784_strobe_count", 64'(n_wstrobe - wstrobe0), 64'd784);
        chk("w784_ready_low_cycles", 64'(n_ready_low - ready_low0), 64'd1);

        // Abort after 2 of 5 weights, then a normal packet
        exp_layer = 6'd2; exp_neuron = 8'd7;
        push_ev(K_W, 32'hA1); push_ev(K_W, 32'hA2); push_ev(K_E, 32'd0);
        send(32'h4207_0005);
        send(32'hA1); send(32'hA2);
        i_abort = 1'b1;
        send(32'hA3);
        i_abort = 1'b0;
        chk("abort_to_idle", {63'd0, o_busy}, 64'd0);
        idle(2);
        exp_layer = 6'd3; exp_neuron = 8'd8;
        push_ev(K_W, 32'hB1); push_ev(K_W, 32'hB2); push_ev(K_D, 32'd0);
        send(32'h4308_0002);
        send(32'hB1); send(32'hB2);
        idle(4);

        // Abort while idle is ignored
        i_abort = 1'b1;
        idle(2);
        i_abort = 1'b0;

        // Asynchronous reset mid-WEIGHT
        exp_layer = 6'd4; exp_neuron = 8'd9;
        push_ev(K_W, 32'hC1); push_ev(K_W, 32'hC2);
        send(32'h4409_0004);
        send(32'hC1); send(32'hC2);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("areset_ready", {63'd0, o_cfg_ready}, 64'd0);
        chk("areset_flags", {59'd0, o_weight_valid, o_bias_valid, o_busy, o_done, o_error}, 64'd0);
        chk("areset_ids", {o_layer_id, o_neuron_id}, 64'd0);
        chk("areset_values", {o_weight_value, o_bias_value}, 64'd0);
        #14 reset = 1'b0;
        exp_layer = 6'd0; exp_neuron = 8'd0;
        @(posedge clk); #1;
        chk("ready_after_areset", {63'd0, o_cfg_ready}, 64'd1);
        chk("idle_after_areset", {63'd0, o_busy}, 64'd0);
        idle(6);

        // Short bias packet after reset recovery
        exp_layer = 6'd5; exp_neuron = 8'd1;
        push_ev(K_B, 32'hDEAD_BEEF); push_ev(K_D, 32'd0);
        send(32'h8501_FFFF);
        send(32'hDEAD_BEEF);
        idle(6);

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
